// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: requester indices, GPR count, address type.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package wb_arbiter_pkg;

    // Requester index. It is also the bit position in the req/gnt vectors.
    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_CSR = 2'd2
    } req_e;

    localparam int NUM_REQ = 3;
    localparam int NUM_GPR = 32;

    typedef logic [4:0] gpr_addr_t;

    // Next requester in the circular search order ALU -> LSU -> CSR -> ALU.
    function automatic req_e next_req(input req_e cur);
        req_e nxt;
        case (cur)
            REQ_ALU: nxt = REQ_LSU;
            REQ_LSU: nxt = REQ_CSR;
            default: nxt = REQ_ALU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// 3-way grant generator: round-robin after the last grant (RR_EN=1) or fixed ALU>LSU>CSR.
// Latency: grant is combinational from req in the same cycle; the pointer updates on the edge.
// Backpressure: at most one grant per cycle; no grant while rst is high; losers wait for a later cycle.
module rr_arbiter3
    import wb_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    // Last granted requester. It resets to CSR so ALU is searched first after reset.
    req_e ptr_q;
    req_e first;
    req_e second;

    // Search order starts one past the pointer and wraps back to the pointer itself.
    always_comb begin
        first  = next_req(ptr_q);
        second = next_req(first);
    end

    // One-hot grant. Requests seen during reset are never granted.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (RR_EN) begin
                if (req[first]) begin
                    gnt[first] = 1'b1;
                end else if (req[second]) begin
                    gnt[second] = 1'b1;
                end else if (req[ptr_q]) begin
                    gnt[ptr_q] = 1'b1;
                end
            end else begin
                if (req[REQ_ALU]) begin
                    gnt[REQ_ALU] = 1'b1;
                end else if (req[REQ_LSU]) begin
                    gnt[REQ_LSU] = 1'b1;
                end else if (req[REQ_CSR]) begin
                    gnt[REQ_CSR] = 1'b1;
                end
            end
        end
    end

    // The pointer moves only on an actual grant, so idle cycles keep fairness intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_CSR;
        end else if (gnt[REQ_ALU]) begin
            ptr_q <= REQ_ALU;
        end else if (gnt[REQ_LSU]) begin
            ptr_q <= REQ_LSU;
        end else if (gnt[REQ_CSR]) begin
            ptr_q <= REQ_CSR;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the GPR write port between ALU/LSU/CSR and keeps a pending-destination scoreboard.
// Latency: grant same cycle; wb_* registered 1 cycle after grant; busy set/clear visible 1 cycle later.
// Backpressure: one write-back per cycle via vld/rdy; non-granted units hold vld until rdy.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            alu_wb_vld,
    input  logic [4:0]      alu_wb_addr,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_rdy,

    input  logic            lsu_wb_vld,
    input  logic [4:0]      lsu_wb_addr,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_rdy,

    input  logic            csr_wb_vld,
    input  logic [4:0]      csr_wb_addr,
    input  logic [XLEN-1:0] csr_wb_data,
    output logic            csr_wb_rdy,

    input  logic            iss_vld,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            raw_stall,
    output logic            waw_stall,

    output logic            wb_vld,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;

    logic               gnt_any;
    gpr_addr_t          gnt_addr;
    logic [XLEN-1:0]    gnt_data;

    logic [NUM_GPR-1:1] busy_q;
    logic [NUM_GPR-1:1] busy_nxt;
    logic [NUM_GPR-1:0] busy;

    logic               byp1;
    logic               byp2;

    assign req = {csr_wb_vld, lsu_wb_vld, alu_wb_vld};

    rr_arbiter3 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_wb_rdy = gnt[REQ_ALU];
    assign lsu_wb_rdy = gnt[REQ_LSU];
    assign csr_wb_rdy = gnt[REQ_CSR];

    // Select the winning write; the grant is one-hot so the chain order does not matter.
    always_comb begin
        gnt_any  = |gnt;
        gnt_addr = '0;
        gnt_data = '0;
        if (gnt[REQ_ALU]) begin
            gnt_addr = alu_wb_addr;
            gnt_data = alu_wb_data;
        end else if (gnt[REQ_LSU]) begin
            gnt_addr = lsu_wb_addr;
            gnt_data = lsu_wb_data;
        end else if (gnt[REQ_CSR]) begin
            gnt_addr = csr_wb_addr;
            gnt_data = csr_wb_data;
        end
    end

    // Output register: x0 writes are consumed without a GPR write; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_vld  <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_vld <= gnt_any && (gnt_addr != '0);
            if (gnt_any && (gnt_addr != '0)) begin
                wb_addr <= gnt_addr;
                wb_data <= gnt_data;
            end
        end
    end

    // Next busy state per register: an issuing instruction sets, a granted write clears,
    // and a same-cycle set beats the clear because the new instruction now owns the register.
    // x0 never appears here: gnt_addr==0 and iss_rd==0 cannot match any index >= 1.
    always_comb begin
        busy_nxt = busy_q;
        for (int i = 1; i < NUM_GPR; i++) begin
            if (gnt_any && (gnt_addr == gpr_addr_t'(i))) begin
                busy_nxt[i] = 1'b0;
            end
            if (iss_vld && (iss_rd == gpr_addr_t'(i))) begin
                busy_nxt[i] = 1'b1;
            end
        end
    end

    // Scoreboard register updates on the same edge that loads the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = {busy_q, 1'b0};

    // A source matched by this cycle's granted write is covered by the RMU bypass.
    always_comb begin
        byp1      = gnt_any && (gnt_addr == rs1) && (rs1 != '0);
        byp2      = gnt_any && (gnt_addr == rs2) && (rs2 != '0);
        raw_stall = (busy[rs1] && !byp1) || (busy[rs2] && !byp2);
        // Not qualified by iss_vld so decode can use it to gate the issue itself.
        waw_stall = busy[iss_rd] && (iss_rd != '0);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run against a model.
// Latency: n/a.
// Backpressure: requesters in the random run hold vld/addr/data until they see rdy.
module tb_wb_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_wb_vld = 1'b0, lsu_wb_vld = 1'b0, csr_wb_vld = 1'b0;
    logic [4:0]      alu_wb_addr = '0, lsu_wb_addr = '0, csr_wb_addr = '0;
    logic [XLEN-1:0] alu_wb_data = '0, lsu_wb_data = '0, csr_wb_data = '0;
    logic            iss_vld = 1'b0;
    logic [4:0]      iss_rd = '0, rs1 = '0, rs2 = '0;

    logic            alu_wb_rdy, lsu_wb_rdy, csr_wb_rdy;
    logic            raw_stall, waw_stall, wb_vld;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            f_alu_rdy, f_lsu_rdy, f_csr_rdy;
    logic            f_raw, f_waw, f_wb_vld;
    logic [4:0]      f_wb_addr;
    logic [XLEN-1:0] f_wb_data;

    wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_vld(alu_wb_vld), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data), .alu_wb_rdy(alu_wb_rdy),
        .lsu_wb_vld(lsu_wb_vld), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data), .lsu_wb_rdy(lsu_wb_rdy),
        .csr_wb_vld(csr_wb_vld), .csr_wb_addr(csr_wb_addr), .csr_wb_data(csr_wb_data), .csr_wb_rdy(csr_wb_rdy),
        .iss_vld(iss_vld), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .raw_stall(raw_stall), .waw_stall(waw_stall),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fix (
        .clk(clk), .rst(rst),
        .alu_wb_vld(alu_wb_vld), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data), .alu_wb_rdy(f_alu_rdy),
        .lsu_wb_vld(lsu_wb_vld), .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data), .lsu_wb_rdy(f_lsu_rdy),
        .csr_wb_vld(csr_wb_vld), .csr_wb_addr(csr_wb_addr), .csr_wb_data(csr_wb_data), .csr_wb_rdy(f_csr_rdy),
        .iss_vld(iss_vld), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .raw_stall(f_raw), .waw_stall(f_waw),
        .wb_vld(f_wb_vld), .wb_addr(f_wb_addr), .wb_data(f_wb_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: pending set, last granted unit (0=ALU,1=LSU,2=CSR), expected outputs.
    bit [31:0]       busy_m = '0;
    int              last_m = 2;
    logic            m_wb_vld = 1'b0;
    logic [4:0]      m_wb_addr = '0;
    logic [XLEN-1:0] m_wb_data = '0;

    function automatic bit [2:0] vldv();
        return {csr_wb_vld, lsu_wb_vld, alu_wb_vld};
    endfunction

    function automatic bit [2:0] rdyv();
        return {csr_wb_rdy, lsu_wb_rdy, alu_wb_rdy};
    endfunction

    // Winner index or -1: round-robin searches from the unit after 'last', else fixed ALU>LSU>CSR.
    function automatic int exp_grant(bit [2:0] v, int last, bit rr, bit r);
        if (r) return -1;
        if (rr) begin
            for (int k = 1; k <= 3; k++) begin
                if (v[(last + k) % 3]) return (last + k) % 3;
            end
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (v[u]) return u;
            end
        end
        return -1;
    endfunction

    function automatic bit [2:0] onehot(int g);
        bit [2:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [4:0] addr_of(int g);
        if (g == 0) return alu_wb_addr;
        if (g == 1) return lsu_wb_addr;
        return csr_wb_addr;
    endfunction

    function automatic logic [XLEN-1:0] data_of(int g);
        if (g == 0) return alu_wb_data;
        if (g == 1) return lsu_wb_data;
        return csr_wb_data;
    endfunction

    function automatic bit exp_raw(int g);
        bit [4:0] ga;
        bit s1, s2;
        ga = (g >= 0) ? addr_of(g) : 5'd0;
        s1 = busy_m[rs1] && !(g >= 0 && ga == rs1 && rs1 != 0);
        s2 = busy_m[rs2] && !(g >= 0 && ga == rs2 && rs2 != 0);
        return s1 || s2;
    endfunction

    function automatic bit exp_waw();
        return busy_m[iss_rd] && (iss_rd != 0);
    endfunction

    // Advance one clock edge and apply the same edge to the reference state.
    task automatic cycle();
        int g;
        bit [4:0] ga;
        logic [XLEN-1:0] gd;
        g = exp_grant(vldv(), last_m, 1'b1, rst);
        ga = (g >= 0) ? addr_of(g) : 5'd0;
        gd = (g >= 0) ? data_of(g) : '0;
        @(posedge clk);
        if (rst) begin
            busy_m = '0; last_m = 2; m_wb_vld = 1'b0; m_wb_addr = '0; m_wb_data = '0;
        end else begin
            if (g >= 0) begin
                last_m = g;
                busy_m[ga] = 1'b0;
            end
            if (iss_vld && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            busy_m[0] = 1'b0;
            m_wb_vld = (g >= 0) && (ga != 0);
            if (m_wb_vld) begin
                m_wb_addr = ga;
                m_wb_data = gd;
            end
        end
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0; rs1 = 5'd5; rs2 = 5'd7;
        settle();
        total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL reset_wb_vld got=%0b exp=0", wb_vld); end
        total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL reset_wb_addr got=%0d exp=0", wb_addr); end
        total++; if (wb_data !== '0) begin bad++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
        total++; if (rdyv() !== 3'b000) begin bad++; $display("FAIL reset_rdy got=%b exp=000", rdyv()); end
        total++; if (raw_stall !== 1'b0) begin bad++; $display("FAIL reset_raw got=%0b exp=0", raw_stall); end
        total++; if (waw_stall !== 1'b0) begin bad++; $display("FAIL reset_waw got=%0b exp=0", waw_stall); end
    endtask

    task automatic test_rr();
        int g;
        alu_wb_vld = 1; lsu_wb_vld = 1; csr_wb_vld = 1;
        alu_wb_addr = 5'd1; lsu_wb_addr = 5'd2; csr_wb_addr = 5'd3;
        alu_wb_data = 64'hA1; lsu_wb_data = 64'hB2; csr_wb_data = 64'hC3;
        for (int n = 0; n < 6; n++) begin
            settle();
            g = exp_grant(vldv(), last_m, 1'b1, rst);
            total++; if (rdyv() !== onehot(n % 3)) begin bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", n, rdyv(), onehot(n % 3)); end
            total++; if ({f_csr_rdy, f_lsu_rdy, f_alu_rdy} !== 3'b001) begin bad++; $display("FAIL fixed_grant cyc=%0d got=%b exp=001", n, {f_csr_rdy, f_lsu_rdy, f_alu_rdy}); end
            cycle();
            total++; if (wb_vld !== 1'b1 || wb_addr !== 5'(n % 3 + 1)) begin bad++; $display("FAIL rr_wb cyc=%0d got=%0b/%0d exp=1/%0d", n, wb_vld, wb_addr, n % 3 + 1); end
            total++; if (wb_data !== m_wb_data || g != n % 3) begin bad++; $display("FAIL rr_data cyc=%0d got=%0h exp=%0h", n, wb_data, m_wb_data); end
        end
        alu_wb_vld = 0; lsu_wb_vld = 0; csr_wb_vld = 0;
        cycle();
        total++; if (wb_vld !== 1'b0 || wb_addr !== 5'd3) begin bad++; $display("FAIL idle_hold got=%0b/%0d exp=0/3", wb_vld, wb_addr); end
    endtask

    task automatic test_single();
        alu_wb_vld = 1; alu_wb_addr = 5'd3; alu_wb_data = 64'hDEAD;
        settle();
        total++; if (rdyv() !== 3'b001) begin bad++; $display("FAIL single_rdy got=%b exp=001", rdyv()); end
        cycle();
        alu_wb_vld = 0;
        settle();
        total++; if (wb_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%0b exp=1", wb_vld); end
        total++; if (wb_addr !== 5'd3) begin bad++; $display("FAIL single_addr got=%0d exp=3", wb_addr); end
        total++; if (wb_data !== 64'hDEAD) begin bad++; $display("FAIL single_data got=%0h exp=dead", wb_data); end
        total++; if (rdyv() !== 3'b000) begin bad++; $display("FAIL rdy_without_vld got=%b exp=000", rdyv()); end
        cycle();
    endtask

    task automatic test_scoreboard();
        iss_vld = 1; iss_rd = 5'd9; rs1 = 0; rs2 = 0;
        cycle();
        iss_vld = 0; rs1 = 5'd9;
        settle();
        total++; if (raw_stall !== 1'b1) begin bad++; $display("FAIL sb_raw_c1 got=%0b exp=1", raw_stall); end
        total++; if (waw_stall !== 1'b1) begin bad++; $display("FAIL sb_waw_c1 got=%0b exp=1", waw_stall); end
        cycle(); cycle();
        rs1 = 0; rs2 = 5'd9;
        settle();
        total++; if (raw_stall !== 1'b1) begin bad++; $display("FAIL sb_raw_rs2 got=%0b exp=1", raw_stall); end
        cycle();
        rs1 = 5'd9; rs2 = 0;
        lsu_wb_vld = 1; lsu_wb_addr = 5'd9; lsu_wb_data = 64'h99;
        settle();
        total++; if (lsu_wb_rdy !== 1'b1) begin bad++; $display("FAIL sb_lsu_rdy got=%0b exp=1", lsu_wb_rdy); end
        total++; if (raw_stall !== 1'b0) begin bad++; $display("FAIL sb_bypass got=%0b exp=0", raw_stall); end
        total++; if (waw_stall !== 1'b1) begin bad++; $display("FAIL sb_waw_c4 got=%0b exp=1", waw_stall); end
        cycle();
        lsu_wb_vld = 0;
        settle();
        total++; if (raw_stall !== 1'b0 || waw_stall !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%0b/%0b exp=0/0", raw_stall, waw_stall); end
        total++; if (wb_vld !== 1'b1 || wb_addr !== 5'd9) begin bad++; $display("FAIL sb_wb got=%0b/%0d exp=1/9", wb_vld, wb_addr); end
    endtask

    task automatic test_set_clear();
        iss_vld = 1; iss_rd = 5'd12;
        cycle();
        iss_vld = 1; iss_rd = 5'd12;
        csr_wb_vld = 1; csr_wb_addr = 5'd12; csr_wb_data = 64'h1212;
        settle();
        total++; if (csr_wb_rdy !== 1'b1) begin bad++; $display("FAIL sc_csr_rdy got=%0b exp=1", csr_wb_rdy); end
        cycle();
        iss_vld = 0; csr_wb_vld = 0; rs1 = 5'd12;
        settle();
        total++; if (waw_stall !== 1'b1) begin bad++; $display("FAIL sc_set_wins got=%0b exp=1", waw_stall); end
        total++; if (raw_stall !== 1'b1) begin bad++; $display("FAIL sc_raw got=%0b exp=1", raw_stall); end
        total++; if (wb_vld !== 1'b1 || wb_addr !== 5'd12) begin bad++; $display("FAIL sc_wb got=%0b/%0d exp=1/12", wb_vld, wb_addr); end
        csr_wb_vld = 1;
        cycle();
        csr_wb_vld = 0;
        settle();
        total++; if (waw_stall !== 1'b0) begin bad++; $display("FAIL sc_clear got=%0b exp=0", waw_stall); end
    endtask

    task automatic test_x0();
        alu_wb_vld = 1; alu_wb_addr = 5'd0; alu_wb_data = 64'hFF;
        iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        settle();
        total++; if (alu_wb_rdy !== 1'b1) begin bad++; $display("FAIL x0_rdy got=%0b exp=1", alu_wb_rdy); end
        cycle();
        alu_wb_vld = 0;
        settle();
        total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL x0_wb_vld got=%0b exp=0", wb_vld); end
        total++; if (wb_addr !== 5'd12 || wb_data !== 64'h1212) begin bad++; $display("FAIL x0_hold got=%0d/%0h exp=12/1212", wb_addr, wb_data); end
        total++; if (waw_stall !== 1'b0 || raw_stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b/%0b exp=0/0", waw_stall, raw_stall); end
    endtask

    task automatic test_rst_mid();
        iss_vld = 1; iss_rd = 5'd4;
        cycle();
        iss_vld = 0;
        settle();
        total++; if (waw_stall !== 1'b1) begin bad++; $display("FAIL rm_busy got=%0b exp=1", waw_stall); end
        lsu_wb_vld = 1; lsu_wb_addr = 5'd7; lsu_wb_data = 64'h77;
        alu_wb_vld = 1; alu_wb_addr = 5'd8;
        rst = 1;
        settle();
        total++; if (rdyv() !== 3'b000) begin bad++; $display("FAIL rm_rdy_in_rst got=%b exp=000", rdyv()); end
        cycle();
        rst = 0; alu_wb_vld = 0;
        settle();
        total++; if (waw_stall !== 1'b0) begin bad++; $display("FAIL rm_busy_cleared got=%0b exp=0", waw_stall); end
        total++; if (wb_vld !== 1'b0 || wb_addr !== 5'd0 || wb_data !== '0) begin bad++; $display("FAIL rm_out_cleared got=%0b/%0d/%0h exp=0/0/0", wb_vld, wb_addr, wb_data); end
        total++; if (lsu_wb_rdy !== 1'b1) begin bad++; $display("FAIL rm_represent got=%0b exp=1", lsu_wb_rdy); end
        cycle();
        lsu_wb_vld = 0;
        settle();
        total++; if (wb_vld !== 1'b1 || wb_addr !== 5'd7) begin bad++; $display("FAIL rm_wb got=%0b/%0d exp=1/7", wb_vld, wb_addr); end
    endtask

    task automatic test_random();
        bit              pend [3];
        logic [4:0]      pa [3];
        logic [XLEN-1:0] pd [3];
        int g;
        int gf;
        for (int u = 0; u < 3; u++) begin pend[u] = 0; pa[u] = '0; pd[u] = '0; end
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 3; u++) begin
                if (!pend[u] && $urandom_range(0, 1) == 1) begin
                    pend[u] = 1;
                    pa[u] = 5'($urandom_range(0, 31));
                    pd[u] = {$urandom, $urandom};
                end
            end
            alu_wb_vld = pend[0]; alu_wb_addr = pa[0]; alu_wb_data = pd[0];
            lsu_wb_vld = pend[1]; lsu_wb_addr = pa[1]; lsu_wb_data = pd[1];
            csr_wb_vld = pend[2]; csr_wb_addr = pa[2]; csr_wb_data = pd[2];
            iss_vld = ($urandom_range(0, 2) == 0);
            iss_rd  = 5'($urandom_range(0, 31));
            rs1     = 5'($urandom_range(0, 31));
            rs2     = 5'($urandom_range(0, 31));
            rst     = ($urandom_range(0, 63) == 0);
            settle();
            g  = exp_grant(vldv(), last_m, 1'b1, rst);
            gf = exp_grant(vldv(), 0, 1'b0, rst);
            total++; if (rdyv() !== onehot(g)) begin bad++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, rdyv(), onehot(g)); end
            total++; if ({f_csr_rdy, f_lsu_rdy, f_alu_rdy} !== onehot(gf)) begin bad++; $display("FAIL rnd_fix_rdy n=%0d got=%b exp=%b", n, {f_csr_rdy, f_lsu_rdy, f_alu_rdy}, onehot(gf)); end
            total++; if (raw_stall !== exp_raw(g)) begin bad++; $display("FAIL rnd_raw n=%0d got=%0b exp=%0b", n, raw_stall, exp_raw(g)); end
            total++; if (waw_stall !== exp_waw()) begin bad++; $display("FAIL rnd_waw n=%0d got=%0b exp=%0b", n, waw_stall, exp_waw()); end
            cycle();
            if (g >= 0) pend[g] = 0;
            total++; if (wb_vld !== m_wb_vld) begin bad++; $display("FAIL rnd_wb_vld n=%0d got=%0b exp=%0b", n, wb_vld, m_wb_vld); end
            total++; if (wb_addr !== m_wb_addr || wb_data !== m_wb_data) begin bad++; $display("FAIL rnd_wb n=%0d got=%0d/%0h exp=%0d/%0h", n, wb_addr, wb_data, m_wb_addr, m_wb_data); end
        end
        rst = 0; iss_vld = 0;
        alu_wb_vld = 0; lsu_wb_vld = 0; csr_wb_vld = 0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_scoreboard();
        test_set_clear();
        test_x0();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and register scoreboard that shares the single GPR write port between the ALU, LSU and CSR units. It sits between the execution units and the register-file management unit (RMU). It grants one writer per cycle with valid/ready handshakes and registers the winning write onto the GPR port. It also tracks pending destination registers so issue can stall on RAW/WAW hazards.

## Interface
Parameters:
- XLEN, 64, data width of write-back data.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority ALU > LSU > CSR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_wb_vld / lsu_wb_vld / csr_wb_vld  in  1 each  write-back request from the named unit.
- alu_wb_addr / lsu_wb_addr / csr_wb_addr  in  5 each  destination GPR.
- alu_wb_data / lsu_wb_data / csr_wb_data  in  XLEN each  write data.
- alu_wb_rdy / lsu_wb_rdy / csr_wb_rdy  out  1 each  request accepted this cycle.
- iss_vld  in  1  instruction issuing this cycle with a destination.
- iss_rd  in  5  destination of the issuing instruction.
- rs1, rs2  in  5 each  source registers of the instruction in decode.
- raw_stall  out  1  rs1 or rs2 is pending and not bypassable.
- waw_stall  out  1  iss_rd is already pending.
- wb_vld  out  1  registered GPR write enable to RMU.
- wb_addr  out  5  registered GPR write address.
- wb_data  out  XLEN  registered GPR write data.

## Operation
- Arbitration:
  - Each cycle, at most one of the three requesters gets its rdy, combinationally from the current vld inputs.
  - RR_EN=1: search order starts at the unit after the last granted; order ALU→LSU→CSR→ALU. The pointer advances only on an actual grant.
  - RR_EN=0: fixed ALU > LSU > CSR; the pointer is unused.
- Handshake:
  - A transfer occurs when vld & rdy.
  - A requester holds vld, addr and data stable until rdy.
  - rdy never asserts without vld.
- Output stage:
  - A granted transfer with addr≠0 loads wb_vld=1, wb_addr and wb_data on the next edge.
  - With no grant, wb_vld=0 next cycle; wb_addr and wb_data hold their last values.
  - Writes to x0 are accepted (rdy=1) but produce wb_vld=0 and do not touch the scoreboard.
- Scoreboard:
  - busy[31:1] is a register; busy[0] is hard-wired 0.
  - iss_vld with iss_rd≠0 sets busy[iss_rd].
  - A granted transfer clears busy[addr] on the same edge the output register loads.
  - Simultaneous set and clear of the same register: set wins, since the newer instruction owns it.
- Hazards:
  - raw_stall = (busy[rs1] & !byp1) | (busy[rs2] & !byp2).
  - byp_n = granted-this-cycle & (granted addr == rs_n), with rs_n≠0. This matches RMU bypassing the in-flight write.
  - waw_stall = busy[iss_rd] & iss_rd≠0. It is independent of iss_vld, so decode may use it to gate iss_vld.

## Timing
- Reset values:
  - wb_vld=0, wb_addr=0, wb_data=0.
  - All busy bits 0.
  - RR pointer = CSR, so ALU is searched first.
  - All rdy outputs follow the combinational rule; no request → 0.
- Latency:
  - Grant to wb_vld: 1 cycle.
  - Issue to busy visible on raw_stall/waw_stall: 1 cycle.
  - Grant to busy cleared: 1 cycle.
- Throughput: one write-back per cycle; no bubbles under continuous requests.
- Reset mid-operation:
  - A request pending during rst is not granted; all rdy are forced 0 while rst=1.
  - Scoreboard and output register are cleared; requesters re-present after reset.
- Simultaneous requests to the same addr from two units: only one is granted per cycle; the loser is served in a later cycle. Ordering between units is the issuer's responsibility.
- No combinational path from wb_* inputs of RMU back into this block.

## Structure
- The shared package holds:
  - the requester-index enum (REQ_ALU=0, REQ_LSU=1, REQ_CSR=2);
  - NUM_GPR=32;
  - the GPR-address typedef (5-bit).
- One sub-module, rr_arbiter3: a 3-way round-robin/fixed-priority grant generator with pointer register, selected by the RR_EN parameter.
- Scoreboard and output register stay in wb_arbiter.

## Test plan
- Reset then idle: wb_vld=0, all rdy=0, raw_stall=0 with rs1=5, rs2=7.
- ALU only, addr=3, data=0xDEAD: alu_wb_rdy=1 in the same cycle; next cycle wb_vld=1, wb_addr=3, wb_data=0xDEAD.
- All three request continuously with RR_EN=1: grants ALU, LSU, CSR, ALU… one per cycle. With RR_EN=0: ALU every cycle, LSU and CSR rdy=0.
- iss_vld rd=9 at cycle 0:
  - cycle 1, rs1=9: raw_stall=1 and waw_stall=1 for iss_rd=9.
  - LSU write of addr 9 granted at cycle 4: raw_stall=0 that same cycle via bypass; busy[9]=0 from cycle 5.
- Same-cycle iss_vld rd=12 and granted CSR write to addr 12 (earlier pending): busy[12] remains 1 next cycle.
- ALU write addr=0, data=0xFF: alu_wb_rdy=1, next cycle wb_vld=0. rst pulsed while busy[4]=1 and LSU requesting: rdy=0 during rst, busy cleared afterwards.
